// File: rtl/l2_msg_pkg.sv
// Shared types for the L2 message scheduler: FSM states, message codes, field widths.
package l2_msg_pkg;

   localparam int TAG_W  = 26;
   localparam int SRC_W  = 6;
   localparam int DATA_W = 64;
   localparam int TYPE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   localparam logic [TYPE_W-1:0] MSG_STORE_REQ    = 8'h02;
   localparam logic [TYPE_W-1:0] MSG_DATA_ACK     = 8'h11;
   localparam logic [TYPE_W-1:0] MSG_NODATA_ACK   = 8'h12;
   localparam logic [TYPE_W-1:0] MSG_LOAD_FWDACK  = 8'h13;
   localparam logic [TYPE_W-1:0] MSG_STORE_FWDACK = 8'h14;
   localparam logic [TYPE_W-1:0] MSG_INV_FWDACK   = 8'h1d;

   typedef struct packed {
      logic              sel;
      logic [TYPE_W-1:0] mtype;
      logic [SRC_W-1:0]  src;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } slot_t;

   typedef struct packed {
      logic [TYPE_W-1:0] mtype;
      logic [SRC_W-1:0]  src;
      logic [TAG_W-1:0]  tag;
   } cur_t;

endpackage

// File: rtl/l2_wait_timer.sv
// Saturating response-wait counter; o_expire is combinational in the enabled cycle that
// brings the count to TIMEOUT_CYC. No backpressure; i_clr has priority over i_en.
module l2_wait_timer #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_expire
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
   localparam logic [7:0] CNT_TOP  = 8'(TIMEOUT_CYC);

   logic [7:0] r_cnt;

   assign o_expire = i_en && (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != CNT_TOP)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/l2_msg_sched.sv
// msg1/msg3 arbiter feeding a one-entry slot to the L2 engine; slot offered the cycle after accept.
// Inputs stall via combinational ready while the slot is busy; off-tag msg3 stalls during WAIT.
module l2_msg_sched
   import l2_msg_pkg::*;
#(
   parameter int TIMEOUT_CYC     = 255,
   parameter int MSG3_STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              msg1_valid,
   output logic              msg1_ready,
   input  logic [TYPE_W-1:0] msg1_type,
   input  logic [SRC_W-1:0]  msg1_source,
   input  logic [TAG_W-1:0]  msg1_tag,
   input  logic [DATA_W-1:0] msg1_data,
   input  logic              msg3_valid,
   output logic              msg3_ready,
   input  logic [TYPE_W-1:0] msg3_type,
   input  logic [SRC_W-1:0]  msg3_source,
   input  logic [TAG_W-1:0]  msg3_tag,
   input  logic [DATA_W-1:0] msg3_data,
   output logic              eng_valid,
   input  logic              eng_ready,
   output logic              eng_sel,
   output logic [TYPE_W-1:0] eng_type,
   output logic [SRC_W-1:0]  eng_source,
   output logic [TAG_W-1:0]  eng_tag,
   output logic [DATA_W-1:0] eng_data,
   input  logic              eng_done,
   input  logic              eng_wait,
   output logic [1:0]        cur_msg_state,
   output logic [TYPE_W-1:0] cur_msg_type,
   output logic [SRC_W-1:0]  cur_msg_source,
   output logic [TAG_W-1:0]  cur_msg_tag,
   output logic              timeout,
   output logic              proto_err
);

   localparam logic [7:0] STREAK_TOP = 8'(MSG3_STREAK_MAX);

   state_e     r_state;
   logic       r_issued;
   slot_t      r_slot;
   cur_t       r_cur;
   logic [7:0] r_streak;
   logic       r_timeout;
   logic       r_proto_err;

   logic  w_streak_full, w_acc1, w_acc3, w_hs, w_expire, w_wait_exit;
   slot_t w_m1_slot, w_m3_slot;

   assign w_streak_full = (r_streak == STREAK_TOP);

   // Once msg3 has won MAX times in a row, a waiting msg1 takes the grant and msg3 backs off.
   always_comb begin
      msg1_ready = 1'b0;
      msg3_ready = 1'b0;
      case (r_state)
         IDLE: begin
            msg1_ready = !msg3_valid || w_streak_full;
            msg3_ready = !(w_streak_full && msg1_valid);
         end
         WAIT:    msg3_ready = (msg3_tag == r_cur.tag);
         default: ;
      endcase
   end

   assign w_acc1      = msg1_valid && msg1_ready;
   assign w_acc3      = msg3_valid && msg3_ready;
   assign eng_valid   = (r_state == ISSUE) && !r_issued;
   assign w_hs        = eng_valid && eng_ready;
   assign w_wait_exit = (r_state == WAIT) && (w_acc3 || w_expire);

   assign w_m1_slot = '{sel: 1'b0, mtype: msg1_type, src: msg1_source, tag: msg1_tag, data: msg1_data};
   assign w_m3_slot = '{sel: 1'b1, mtype: msg3_type, src: msg3_source, tag: msg3_tag, data: msg3_data};

   l2_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
      .i_clk    (clk),
      .i_rst_n  (rst),
      .i_en     (r_state == WAIT),
      .i_clr    (w_wait_exit),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_issued    <= 1'b0;
         r_slot      <= '0;
         r_cur       <= '0;
         r_streak    <= '0;
         r_timeout   <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_acc3) begin
                  r_slot  <= w_m3_slot;
                  r_state <= ISSUE;
                  if (!w_streak_full) r_streak <= r_streak + 8'd1;
               end else if (w_acc1) begin
                  r_slot   <= w_m1_slot;
                  r_cur    <= '{mtype: msg1_type, src: msg1_source, tag: msg1_tag};
                  r_streak <= '0;
                  r_state  <= ISSUE;
               end
               if (eng_done) r_proto_err <= 1'b1;
            end
            ISSUE: begin
               if (eng_done && !(r_issued || w_hs)) begin
                  r_proto_err <= 1'b1;
               end else if (eng_done) begin
                  r_issued <= 1'b0;
                  if (eng_wait && r_slot.sel) begin
                     r_proto_err <= 1'b1;
                     r_state     <= IDLE;
                  end else if (eng_wait) begin
                     r_state <= WAIT;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (w_hs) begin
                  r_issued <= 1'b1;
               end
            end
            WAIT: begin
               if (w_acc3) begin
                  r_slot  <= w_m3_slot;
                  r_state <= ISSUE;
               end else if (w_expire) begin
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end
               if (eng_done) r_proto_err <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign eng_sel        = r_slot.sel;
   assign eng_type       = r_slot.mtype;
   assign eng_source     = r_slot.src;
   assign eng_tag        = r_slot.tag;
   assign eng_data       = r_slot.data;
   assign cur_msg_state  = r_state;
   assign cur_msg_type   = r_cur.mtype;
   assign cur_msg_source = r_cur.src;
   assign cur_msg_tag    = r_cur.tag;
   assign timeout        = r_timeout;
   assign proto_err      = r_proto_err;

endmodule
